// File: rtl/data_mem_responder.sv
// Data-memory responder: synchronous word array with single-cycle writes and
// wait-stated, handshaked reads returned on the processor's mem bus.
module data_mem_responder #(
  parameter int AW   = 8,
  parameter int DW   = 16,
  parameter int WAIT = 1
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic [15:0]   addrM,
  input  logic [DW-1:0] doutM,
  input  logic          wM,
  input  logic          rdM,
  output logic [DW-1:0] mem,
  output logic          memValid,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RWAIT = 2'd1,
    S_RDATA = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_LD = 3'(WAIT);

  state_t        state_q;
  logic [15:0]   rd_addr_q;
  logic [2:0]    cnt_q;
  logic [DW-1:0] mem_q;
  logic          valid_q;
  logic          busy_q;
  logic          err_q;

  logic [DW-1:0] ram_q [2**AW];
  logic [DW-1:0] ram_rd_q;

  logic          wr_in_range_d;
  logic          rd_in_range_d;
  logic          wr_en_d;
  logic [AW-1:0] ram_rd_addr_d;

  assign wr_in_range_d = (addrM >> AW) == 16'd0;
  assign rd_in_range_d = (rd_addr_q >> AW) == 16'd0;
  assign wr_en_d       = (state_q == S_IDLE) && wM && wr_in_range_d;

  // In IDLE the RAM reads the incoming address so the word is already
  // registered when the FSM leaves IDLE; afterwards it keeps re-reading the
  // captured address, which is safe because writes are blocked while busy.
  assign ram_rd_addr_d = (state_q == S_IDLE) ? addrM[AW-1:0] : rd_addr_q[AW-1:0];

  always_ff @(posedge Clock) begin
    if (wr_en_d) begin
      ram_q[addrM[AW-1:0]] <= doutM;
    end
    ram_rd_q <= ram_q[ram_rd_addr_d];
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      rd_addr_q <= 16'd0;
      cnt_q     <= 3'd0;
      mem_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (wM) begin
            // A read arriving with a write is dropped and flagged.
            if (!wr_in_range_d || rdM) begin
              err_q <= 1'b1;
            end
          end else if (rdM) begin
            rd_addr_q <= addrM;
            cnt_q     <= WAIT_LD;
            busy_q    <= 1'b1;
            state_q   <= (WAIT_LD == 3'd0) ? S_RDATA : S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (rdM || wM) begin
            err_q <= 1'b1;
          end
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (rdM || wM) begin
            err_q <= 1'b1;
          end
          if (rd_in_range_d) begin
            mem_q <= ram_rd_q;
          end else begin
            mem_q <= '0;
            err_q <= 1'b1;
          end
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem      = mem_q;
  assign memValid = valid_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT = 0, 1, 3) share stimulus
// and are checked against an array model with latency computed from WAIT.
module tb_data_mem_responder;

  logic        Clock;
  logic        Resetn;
  logic [15:0] addrM;
  logic [15:0] doutM;
  logic        wM;
  logic        rdM;

  logic [15:0] mem_o [3];
  logic [2:0]  vld_o;
  logic [2:0]  busy_o;
  logic [2:0]  err_o;

  int n_cmp = 0;
  int n_mis = 0;

  logic [15:0] ref_mem [256];
  bit          written [256];
  logic [7:0]  wq [$];
  logic [15:0] last_mem;
  logic        err_exp;

  data_mem_responder #(.AW(8), .DW(16), .WAIT(0)) u_w0 (
    .Clock(Clock), .Resetn(Resetn), .addrM(addrM), .doutM(doutM), .wM(wM), .rdM(rdM),
    .mem(mem_o[0]), .memValid(vld_o[0]), .busy(busy_o[0]), .err(err_o[0]));
  data_mem_responder #(.AW(8), .DW(16), .WAIT(1)) u_w1 (
    .Clock(Clock), .Resetn(Resetn), .addrM(addrM), .doutM(doutM), .wM(wM), .rdM(rdM),
    .mem(mem_o[1]), .memValid(vld_o[1]), .busy(busy_o[1]), .err(err_o[1]));
  data_mem_responder #(.AW(8), .DW(16), .WAIT(3)) u_w3 (
    .Clock(Clock), .Resetn(Resetn), .addrM(addrM), .doutM(doutM), .wM(wM), .rdM(rdM),
    .mem(mem_o[2]), .memValid(vld_o[2]), .busy(busy_o[2]), .err(err_o[2]));

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int wt(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 3);
  endfunction

  function automatic bit in_range(input logic [15:0] a);
    return a[15:8] == 8'd0;
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s[wait=%0d] observed=%0h expected=%0h", tag, wt(i), obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, ".valid"}, i, vld_o[i], 1'b0);
      chk({tag, ".busy"}, i, busy_o[i], 1'b0);
      chk({tag, ".mem"}, i, mem_o[i], last_mem);
      chk({tag, ".err"}, i, err_o[i], err_exp);
    end
  endtask

  // Entered and left just after a falling edge.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input bit with_rd);
    addrM = a; doutM = d; wM = 1'b1; rdM = with_rd;
    @(negedge Clock);
    wM = 1'b0; rdM = 1'b0;
    if (in_range(a)) begin
      ref_mem[a[7:0]] = d;
      if (!written[a[7:0]]) wq.push_back(a[7:0]);
      written[a[7:0]] = 1'b1;
    end else begin
      err_exp = 1'b1;
    end
    if (with_rd) err_exp = 1'b1;
    chk_idle("wr");
    if (with_rd) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge Clock);
        chk_idle("wr_rd_drop");
      end
    end
  endtask

  // memValid is visible in the cycle after edge WAIT+1 (sampled by edge WAIT+2).
  task automatic do_read(input logic [15:0] a, input bit poke, input logic [15:0] poke_a);
    logic [15:0] exp;
    exp = in_range(a) ? ref_mem[a[7:0]] : 16'h0000;
    addrM = a; rdM = 1'b1; wM = 1'b0;
    @(negedge Clock);
    rdM = 1'b0;
    if (poke) begin
      rdM = 1'b1; wM = 1'b1; addrM = poke_a; doutM = 16'($urandom);
    end
    for (int i = 0; i < 3; i++) begin
      chk("rd.busy0", i, busy_o[i], 1'b1);
      chk("rd.valid0", i, vld_o[i], 1'b0);
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clock);
      if (k == 1) begin
        rdM = 1'b0; wM = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        chk("rd.valid", i, vld_o[i], (k == wt(i) + 1));
        chk("rd.busy", i, busy_o[i], (k <= wt(i)));
        chk("rd.mem", i, mem_o[i], (k >= wt(i) + 1) ? exp : last_mem);
      end
    end
    last_mem = exp;
    if (!in_range(a) || poke) err_exp = 1'b1;
    for (int i = 0; i < 3; i++) chk("rd.err", i, err_o[i], err_exp);
  endtask

  task automatic async_reset_check(input string tag);
    Resetn = 1'b0;
    #1;
    last_mem = 16'h0000;
    err_exp = 1'b0;
    chk_idle(tag);
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] d;
    int r;
    Resetn = 1'b0; addrM = 16'h0; doutM = 16'h0; wM = 1'b0; rdM = 1'b0;
    last_mem = 16'h0000; err_exp = 1'b0;
    for (int j = 0; j < 256; j++) written[j] = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    chk_idle("reset");
    Resetn = 1'b1;
    @(negedge Clock);

    do_write(16'h0005, 16'h1234, 1'b0);
    do_read(16'h0005, 1'b0, 16'h0);
    do_write(16'h00FF, 16'hBEEF, 1'b0);
    do_read(16'h00FF, 1'b0, 16'h0);
    do_write(16'h0010, 16'h1234, 1'b0);
    do_read(16'h0010, 1'b0, 16'h0);

    do_write(16'h0000, 16'h5555, 1'b0);
    do_write(16'h0100, 16'hAAAA, 1'b0);
    do_read(16'h0000, 1'b0, 16'h0);
    do_read(16'h0100, 1'b0, 16'h0);

    do_write(16'h0003, 16'h0042, 1'b1);
    do_read(16'h0003, 1'b0, 16'h0);
    do_read(16'h0005, 1'b1, 16'h0003);
    do_read(16'h0003, 1'b0, 16'h0);

    // Reset dropped while every instance is mid-read.
    addrM = 16'h0005; rdM = 1'b1;
    @(negedge Clock);
    rdM = 1'b0;
    #2;
    async_reset_check("rst_mid");
    @(negedge Clock);
    Resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clock);
      chk_idle("rst_after");
    end
    do_read(16'h0005, 1'b0, 16'h0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      d = 16'($urandom);
      if (r <= 4 || wq.size() == 0) begin
        a = {8'h00, 8'($urandom)};
        do_write(a, d, 1'b0);
      end else if (r == 5) begin
        a = {8'($urandom_range(1, 255)), 8'($urandom)};
        do_write(a, d, 1'b0);
      end else if (r <= 8) begin
        a = {8'h00, wq[$urandom_range(0, wq.size() - 1)]};
        do_read(a, ($urandom_range(0, 3) == 0), {8'h00, wq[$urandom_range(0, wq.size() - 1)]});
      end else begin
        a = {8'($urandom_range(1, 255)), 8'($urandom)};
        do_read(a, 1'b0, 16'h0);
      end
    end

    #2;
    async_reset_check("rst_final");
    @(negedge Clock);
    Resetn = 1'b1;
    do_read(16'h0005, 1'b0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
